// File: rtl/aidc_lite_ahb_pkg.sv
// Shared AHB2 encodings and helpers for the aidc_lite bus slaves.
// Holds transfer/size/response enums, slave FSM states and the byte-lane strobe decode.
package aidc_lite_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_t;

  localparam logic [1:0] AHB_OKAY  = 2'd0;
  localparam logic [1:0] AHB_ERROR = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

  // Little-endian byte lanes touched by an access of the given size at addr[1:0].
  function automatic logic [3:0] byte_strb(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] s;
    s = 4'b0000;
    case (hsize)
      HSIZE_BYTE: s = 4'b0001 << addr;
      HSIZE_HALF: s = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: s = 4'b1111;
      default:    s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aidc_lite_sp_ram.sv
// Single-port word RAM with per-byte write enables and asynchronous read.
// Contents are never reset; the owner decides when a write is allowed.
module aidc_lite_sp_ram #(
  parameter int DEPTH_W = 1024,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/aidc_lite_ahb2_slv_mem.sv
// AHB2 slave memory: word RAM behind an address/data-phase FSM with programmable
// wait states and a two-cycle ERROR response for out-of-range or misaligned accesses.
module aidc_lite_ahb2_slv_mem
  import aidc_lite_ahb_pkg::*;
#(
  parameter int DEPTH_W   = 1024,
  parameter int WAIT_NSEQ = 1,
  parameter int WAIT_SEQ  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic [31:0] hrdata_o,
  output logic        hreadyout_o,
  output logic [1:0]  hresp_o
);

  localparam int          AW         = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_W) * 33'd4;
  localparam logic [3:0]  WCNT_NSEQ  = 4'(WAIT_NSEQ);
  localparam logic [3:0]  WCNT_SEQ   = 4'(WAIT_SEQ);

  if (WAIT_NSEQ < 0 || WAIT_NSEQ > 15 || WAIT_SEQ < 0 || WAIT_SEQ > 15) begin : g_bad_wait
    $error("aidc_lite_ahb2_slv_mem: WAIT_NSEQ/WAIT_SEQ must fit the 4-bit wait counter (0..15)");
  end

  slv_state_t    r_state, w_state_nxt;
  logic [3:0]    r_wcnt, w_wcnt_nxt;
  logic [AW-1:0] r_waddr;
  logic [3:0]    r_strb;
  logic          r_write;

  logic          w_slot_free;
  logic          w_accept;
  logic          w_legal;
  logic [3:0]    w_load;
  logic [3:0]    w_we;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Burst type is irrelevant: every beat carries its own address.
  assign w_unused = ^hburst_i;

  // Only cycles in which this slave drives HREADYOUT high can end an address phase.
  assign w_slot_free = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR2);
  assign w_accept    = w_slot_free & hsel_i & hready_i & htrans_i[1];
  assign w_load      = (htrans_i == HTRANS_NONSEQ) ? WCNT_NSEQ : WCNT_SEQ;

  always_comb begin
    w_legal = 1'b1;
    if ({1'b0, haddr_i} >= ADDR_LIMIT) w_legal = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: ;
      HSIZE_HALF: if (haddr_i[0]) w_legal = 1'b0;
      HSIZE_WORD: if (haddr_i[1:0] != 2'b00) w_legal = 1'b0;
      default:    w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_WAIT: begin
        w_wcnt_nxt = r_wcnt - 4'd1;
        if (r_wcnt <= 4'd1) w_state_nxt = ST_DONE;
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: begin
        if (w_accept) begin
          if (w_legal) begin
            w_wcnt_nxt  = w_load;
            w_state_nxt = (w_load != 4'd0) ? ST_WAIT : ST_DONE;
          end else begin
            w_state_nxt = ST_ERR1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Address-phase capture; plain data, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_waddr <= haddr_i[AW+1:2];
      r_write <= hwrite_i;
      r_strb  <= byte_strb(hsize_i, haddr_i[1:0]);
    end
  end

  // Writes commit on the completing edge; a reset on that edge abandons the beat.
  assign w_we = ((r_state == ST_DONE) && r_write && !rst) ? r_strb : 4'b0000;

  aidc_lite_sp_ram #(
    .DEPTH_W (DEPTH_W),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_waddr),
    .i_wdata (hwdata_i),
    .o_rdata (w_rdata)
  );

  assign hreadyout_o = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
  assign hresp_o     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? AHB_ERROR : AHB_OKAY;
  assign hrdata_o    = (((r_state == ST_WAIT) || (r_state == ST_DONE)) && !r_write) ? w_rdata : 32'd0;

endmodule
